// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one bit per clock.
//
// A single full-adder cell and a carry flop process one bit of each operand
// per cycle. Operands are captured when Start is accepted; the result
// (Sum, Cout) is published only at completion and then held until the next
// completion, so partial results are never visible on the outputs.
//
// Optional build macro: SERIAL_ADDER_OVF_EN adds the Ovf output (signed
// two's-complement overflow, registered alongside Sum/Cout).
//
// Handshake: Start is sampled at a rising edge only while Busy is low
// (IDLE or DONE); the accepting edge latches A/B. Busy stays high for the
// WIDTH RUN cycles, then Done pulses for exactly one cycle with Sum/Cout
// valid. Start high during the Done cycle begins the next addition with no
// idle gap. Reset wins over Start on the same edge.

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             Ovf,
`endif
    output logic [1:0]       o_dbg_state
);

    // Bit counter only needs to reach WIDTH-1.
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Operand shift registers (shift right, bit 0 is the bit being added).
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    // Carry into the bit currently being added.
    logic             r_carry;
    // Index of the bit currently being added.
    logic [CW-1:0]    r_count;
    // Working sum: the WIDTH-1 bits already produced, newest at the MSB.
    // The final bit is joined on the completion edge, so one bit less of
    // storage is enough.
    logic [WIDTH-2:0] r_work;

    // Published result registers.
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    // Full-adder cell and derived control.
    logic             w_s;
    logic             w_c_next;
    logic [WIDTH-1:0] w_work_next;
    logic             w_accept;
    logic             w_last;

    // One full-adder cell on the current LSBs, plus handshake decodes.
    always_comb begin
        w_s         = r_a[0] ^ r_b[0] ^ r_carry;
        w_c_next    = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
        w_work_next = {w_s, r_work};
        // Start is only honoured when not Busy (IDLE or DONE).
        w_accept    = (r_state != S_RUN) && Start;
        // Final bit: this edge produces the MSB of the result.
        w_last      = (r_state == S_RUN) && (r_count == CW'(WIDTH - 1));
    end

    // Next-state logic for the IDLE/RUN/DONE controller.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                // Back-to-back: a new request here skips IDLE entirely.
                if (Start) begin
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register; reset has priority over any pending Start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Serial datapath: capture operands on accept, shift one bit per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
            r_work  <= '0;
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= 1'b0;
            r_count <= '0;
            r_work  <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_carry <= w_c_next;
            r_count <= r_count + CW'(1);
            r_work  <= w_work_next[WIDTH-1:1];
        end
    end

    // Result registers change only on the completion edge, then hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf  <= 1'b0;
`endif
        end else if (w_last) begin
            r_sum  <= w_work_next;
            r_cout <= w_c_next;
`ifdef SERIAL_ADDER_OVF_EN
            // On the last bit r_carry is the carry into the MSB.
            r_ovf  <= r_carry ^ w_c_next;
`endif
        end
    end

    assign Busy        = (r_state == S_RUN);
    assign Done        = (r_state == S_DONE);
    assign Sum         = r_sum;
    assign Cout        = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign Ovf         = r_ovf;
`endif
    assign o_dbg_state = r_state;

endmodule
